// File: rtl/nios_system_onchip_mem_copier.sv
// Word-by-word copier over a single-port on-chip memory.
// Each word takes a read, a read-wait and a write cycle.
module nios_system_onchip_mem_copier #(
  parameter int DEPTH  = 51200,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              aborted,
  output logic [ADDR_W-1:0] words_done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  output logic              m_clken,
  input  logic [31:0]       m_readdata
);

  typedef enum logic [2:0] {
    IDLE, RD, RWAIT, WR, FIN
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W:0]   src_end;
  logic [ADDR_W:0]   dst_end;
  logic              out_of_range;

  // One extra bit so the end address cannot wrap past DEPTH.
  assign src_end = {1'b0, src_addr} + {1'b0, length};
  assign dst_end = {1'b0, dst_addr} + {1'b0, length};
  assign out_of_range = (src_end > DEPTH_W) || (dst_end > DEPTH_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      remaining    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      aborted      <= 1'b0;
      words_done   <= '0;
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_byteenable <= 4'h0;
      m_writedata  <= '0;
      m_clken      <= 1'b0;
    end else begin
      m_clken <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              state      <= FIN;
              busy       <= 1'b1;
              done       <= 1'b1;
              words_done <= '0;
            end else if (out_of_range) begin
              err <= 1'b1;
            end else begin
              state        <= RD;
              busy         <= 1'b1;
              src          <= src_addr;
              dst          <= dst_addr;
              remaining    <= length;
              words_done   <= '0;
              m_chipselect <= 1'b1;
              m_write      <= 1'b0;
              m_address    <= src_addr;
            end
          end
        end
        RD: begin
          m_chipselect <= 1'b0;
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state        <= WR;
            m_writedata  <= m_readdata;
            m_chipselect <= 1'b1;
            m_write      <= 1'b1;
            m_byteenable <= 4'hF;
            m_address    <= dst;
          end
        end
        WR: begin
          src          <= src + 1'b1;
          dst          <= dst + 1'b1;
          remaining    <= remaining - 1'b1;
          words_done   <= words_done + 1'b1;
          m_chipselect <= 1'b0;
          m_write      <= 1'b0;
          m_byteenable <= 4'h0;
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (remaining == 1) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state        <= RD;
            m_chipselect <= 1'b1;
            m_address    <= src + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
